seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4, meaning pattern length in bits, legal range 2..16.
REQ-002 The block SHALL have parameter COUNT_W, default 8, meaning match-counter width, minimum 2.
REQ-003 The block SHALL have parameter RST_PAT, default 4'b1010 (PAT_W bits), meaning the pattern loaded at reset.
REQ-004 The block SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port x  input  1  serial data bit.
REQ-007 The block SHALL have port x_valid  input  1  x is sampled only when high.
REQ-008 The block SHALL have port pat_load  input  1  load pat_in as the new pattern.
REQ-009 The block SHALL have port pat_in  input  PAT_W  new pattern; bit PAT_W-1 is the first bit received.
REQ-010 The block SHALL have port overlap_en  input  1  1 = overlapping matches, 0 = non-overlapping.
REQ-011 The block SHALL have port cnt_clr  input  1  clear the match counter.
REQ-012 The block SHALL have port z  output  1  registered one-cycle match pulse.
REQ-013 The block SHALL have port match_cnt  output  COUNT_W  saturating count of matches.
REQ-014 The block SHALL have port cnt_sat  output  1  high while match_cnt is at its maximum.
REQ-015 The block SHALL have port fill  output  $clog2(PAT_W+1)  number of valid history bits, 0..PAT_W.

Function
REQ-016 Each accepted bit (x_valid=1) SHALL shift into a PAT_W-bit history register at bit 0, and fill SHALL increment, saturating at PAT_W.
REQ-017 A match SHALL occur on an edge where x_valid=1, fill (before update) >= PAT_W-1, and the updated history equals the pattern.
REQ-018 z SHALL be high for exactly the one cycle following the matching edge (one-cycle latency) and low otherwise.
REQ-019 Cycles with x_valid=0 SHALL leave history, fill and z=0 unchanged; they SHALL NOT break a partial match.
REQ-020 With overlap_en=1, history and fill SHALL be retained after a match, so the pattern suffix may start the next match.
REQ-021 With overlap_en=0, fill SHALL be cleared to 0 on the matching edge, so the next match needs PAT_W fresh bits.
REQ-022 pat_load=1 SHALL update the pattern register on that edge, clear fill to 0, and suppress any match on that edge (pat_load wins over x_valid).
REQ-023 match_cnt SHALL increment by 1 per match and hold at 2^COUNT_W-1; cnt_sat SHALL be the registered indicator of that value.
REQ-024 cnt_clr SHALL zero match_cnt and cnt_sat; with simultaneous cnt_clr and match, match_cnt SHALL be 1.
REQ-025 overlap_en SHALL be sampled on every edge and may change at any time; it takes effect at the next match.

Reset
REQ-026 reset=1 SHALL, on the rising edge, set pattern to RST_PAT, history to 0, fill to 0, z to 0, match_cnt to 0, cnt_sat to 0.
REQ-027 reset SHALL override pat_load, cnt_clr and x_valid; bits presented while reset is high SHALL be discarded.
REQ-028 A match completing on the same edge as reset SHALL NOT produce a z pulse or count.

Structure
REQ-029 Default parameter constants (PAT_W, COUNT_W, RST_PAT) SHALL reside in shared package seq_detector_pkg.
REQ-030 The saturating counter with clear SHALL be a sub-module named sat_counter, parametrised by COUNT_W.
REQ-031 All outputs SHALL be driven directly from flops; there SHALL be no combinational input-to-output path.

Verification
REQ-032 Overlap: PAT_W=4, pattern 1010, overlap_en=1, x=1,0,1,0,1,0 all valid -> z pulses after bits 4 and 6, match_cnt=2.
REQ-033 Non-overlap: same stream, overlap_en=0 -> z pulse after bit 4 only, match_cnt=1, fill=2 at end.
REQ-034 Stall: 1,0,1,0 with x_valid=0 for 3 cycles between each bit -> single z pulse one cycle after the 4th valid bit.
REQ-035 Reload: after 1,0,1 send pat_load with pat_in=0110, then 0,1,1,0 -> no pulse before reload completes, one pulse after last bit.
REQ-036 Saturation: COUNT_W=2, 5 matches -> match_cnt=3, cnt_sat=1; cnt_clr together with a 6th match -> match_cnt=1, cnt_sat=0.
REQ-037 Reset mid-stream: reset asserted on the edge of the 4th bit of 1010 -> z stays 0, fill=0, match_cnt=0, pattern=RST_PAT.

Source files
------------

// File: rtl/seq_detector_pkg.sv
// Shared defaults for the serial pattern detector.
package seq_detector_pkg;
  localparam int                    DEF_PAT_W   = 4;
  localparam int                    DEF_COUNT_W = 8;
  localparam logic [DEF_PAT_W-1:0]  DEF_RST_PAT = 4'b1010;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear; a clear coinciding with an increment yields 1.
module sat_counter #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [COUNT_W-1:0] cnt,
  output logic               sat
);
  localparam logic [COUNT_W-1:0] MAX = '1;

  logic [COUNT_W-1:0] nxt;

  always_comb begin
    nxt = cnt;
    if (clr)
      nxt = inc ? COUNT_W'(1) : '0;
    else if (inc && !sat)
      nxt = cnt + COUNT_W'(1);
  end

  // sat is registered from the next value so it tracks cnt on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      cnt <= nxt;
      sat <= (nxt == MAX);
    end
  end
endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with loadable pattern, overlap control and a saturating match count.
module seq_detector_param
  import seq_detector_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter int               COUNT_W = DEF_COUNT_W,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         x,
  input  logic                         x_valid,
  input  logic                         pat_load,
  input  logic [PAT_W-1:0]             pat_in,
  input  logic                         overlap_en,
  input  logic                         cnt_clr,
  output logic                         z,
  output logic [COUNT_W-1:0]           match_cnt,
  output logic                         cnt_sat,
  output logic [$clog2(PAT_W+1)-1:0]   fill
);
  localparam int FILL_W = $clog2(PAT_W+1);

  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_nxt;
  logic             match;

  assign hist_nxt = {hist[PAT_W-2:0], x};
  // fill of PAT_W-1 plus the incoming bit gives a full window to compare
  assign match = x_valid && !pat_load && (fill >= FILL_W'(PAT_W-1)) && (hist_nxt == pat);

  always_ff @(posedge clk) begin
    if (reset) begin
      pat  <= RST_PAT;
      hist <= '0;
      fill <= '0;
      z    <= 1'b0;
    end else begin
      z <= match;
      if (pat_load) begin
        pat  <= pat_in;
        fill <= '0;
      end else if (x_valid) begin
        hist <= hist_nxt;
        if (match && !overlap_en)
          fill <= '0;
        else if (fill != FILL_W'(PAT_W))
          fill <= fill + FILL_W'(1);
      end
    end
  end

  sat_counter #(.COUNT_W(COUNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (match),
    .cnt   (match_cnt),
    .sat   (cnt_sat)
  );
endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboarded bench: driver pushes reference-model expectations, monitor pops and compares.
module tb_seq_detector_param;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         reset, x, x_valid, pat_load, overlap_en, cnt_clr;
  logic [P-1:0] pat_in;
  logic         z8, z2, sat8, sat2;
  logic [7:0]   cnt8;
  logic [1:0]   cnt2;
  logic [2:0]   fill8, fill2;

  always #5 clk = ~clk;

  seq_detector_param dut8 (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_load(pat_load),
    .pat_in(pat_in), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
    .z(z8), .match_cnt(cnt8), .cnt_sat(sat8), .fill(fill8)
  );

  seq_detector_param #(.COUNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_load(pat_load),
    .pat_in(pat_in), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
    .z(z2), .match_cnt(cnt2), .cnt_sat(sat2), .fill(fill2)
  );

  typedef struct {
    int edge_n;
    bit z;
    int c8;
    bit s8;
    int c2;
    bit s2;
    int fill;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // reference model: recent accepted bits, count of fresh bits, counters
  bit [P-1:0] m_pat;
  bit         m_hq[$];
  int         m_fill, m_c8, m_c2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp_v);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].edge_n <= cyc) begin
        e = sbq.pop_front();
        chk("z8",    int'(z8),    int'(e.z));
        chk("z2",    int'(z2),    int'(e.z));
        chk("cnt8",  int'(cnt8),  e.c8);
        chk("sat8",  int'(sat8),  int'(e.s8));
        chk("cnt2",  int'(cnt2),  e.c2);
        chk("sat2",  int'(sat2),  int'(e.s2));
        chk("fill8", int'(fill8), e.fill);
        chk("fill2", int'(fill2), e.fill);
      end
    end
  end

  task automatic step(input bit r, input bit xv, input bit xb, input bit pl,
                      input bit [P-1:0] pin, input bit ov, input bit clr);
    exp_t e;
    bit   m;
    @(negedge clk);
    reset = r; x_valid = xv; x = xb; pat_load = pl; pat_in = pin;
    overlap_en = ov; cnt_clr = clr;
    m = 1'b0;
    if (r) begin
      m_pat = 4'b1010; m_hq.delete(); m_fill = 0; m_c8 = 0; m_c2 = 0;
    end else begin
      if (pl) begin
        m_pat = pin; m_fill = 0;
      end else if (xv) begin
        m_hq.push_back(xb);
        if (m_hq.size() > P) void'(m_hq.pop_front());
        if (m_fill < P) m_fill++;
        if (m_fill == P) begin
          m = 1'b1;
          for (int i = 0; i < P; i++)
            if (m_hq[i] != m_pat[P-1-i]) m = 1'b0;
        end
        if (m && !ov) m_fill = 0;
      end
      if (clr) begin
        m_c8 = m ? 1 : 0; m_c2 = m_c8;
      end else if (m) begin
        if (m_c8 < 255) m_c8++;
        if (m_c2 < 3) m_c2++;
      end
    end
    e.edge_n = cyc + 1; e.z = m; e.c8 = m_c8; e.s8 = (m_c8 == 255);
    e.c2 = m_c2; e.s2 = (m_c2 == 3); e.fill = m_fill;
    sbq.push_back(e);
  endtask

  task automatic bits(input bit [7:0] b, input int n, input bit ov);
    for (int i = n - 1; i >= 0; i--) step(0, 1, b[i], 0, '0, ov, 0);
  endtask

  task automatic do_reset();
    step(1, 1, 1, 1, 4'b1111, 1, 1);
  endtask

  initial begin : driver
    reset = 1; x = 0; x_valid = 0; pat_load = 0; pat_in = '0; overlap_en = 0; cnt_clr = 0;
    do_reset(); do_reset();
    // overlapping and non-overlapping on 101010
    bits(8'b101010, 6, 1'b1);
    do_reset();
    bits(8'b101010, 6, 1'b0);
    // stalls between valid bits do not break the partial match
    do_reset();
    for (int i = 3; i >= 0; i--) begin
      bit [3:0] s;
      s = 4'b1010;
      step(0, 1, s[i], 0, '0, 1, 0);
      for (int k = 0; k < 3; k++) step(0, 0, 1'($urandom_range(1)), 0, '0, 1, 0);
    end
    // reload mid-stream; the bit on the load edge is discarded
    do_reset();
    bits(8'b101, 3, 1'b1);
    step(0, 1, 0, 1, 4'b0110, 1, 0);
    bits(8'b0110, 4, 1'b1);
    // saturation of the 2-bit counter, then clear with a coincident match
    do_reset();
    bits(8'b1010_1010, 8, 1'b1);
    bits(8'b1010, 4, 1'b1);
    step(0, 1, 1, 0, '0, 1, 0);
    step(0, 1, 0, 0, '0, 1, 1);
    step(0, 0, 0, 0, '0, 1, 0);
    // reset on the edge of the completing bit, then default pattern still active
    do_reset();
    bits(8'b101, 3, 1'b1);
    step(1, 1, 0, 0, '0, 1, 0);
    bits(8'b1010, 4, 1'b0);
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(199) == 0), ($urandom_range(3) != 0), 1'($urandom_range(1)),
           ($urandom_range(39) == 0), 4'($urandom_range(15)), 1'($urandom_range(1)),
           ($urandom_range(29) == 0));
    end
    step(0, 0, 0, 0, '0, 0, 0);
    @(negedge clk); @(negedge clk); #1;
    chk("scoreboard_drain", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
